sync_fifo: RTL and testbench



---
 rtl/sync_fifo.sv | 106 ++++++++++
 tb/tb_sync_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with storage, occupancy count, programmable almost flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have one cycle of latency.
module sync_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int PTR_WIDTH     = 4,
    parameter int AFULL_THRESH  = 2**PTR_WIDTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  oflow,
    output logic                  uflow
);

    localparam int DEPTH = 2**PTR_WIDTH;

    generate
        if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH ||
            AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH) begin : g_bad_thresh
            $error("sync_fifo: almost-full/almost-empty threshold outside 0..DEPTH");
        end
    endgenerate

    localparam logic [PTR_WIDTH:0] AFULL_LVL  = AFULL_THRESH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AEMPTY_LVL = AEMPTY_THRESH[PTR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH:0]    wr_ptr, rd_ptr;
    logic [PTR_WIDTH:0]    wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic                  wr_accept, rd_accept;

    assign wr_accept = wr_en & ~full;
    assign rd_accept = rd_en & ~empty;

    // Next-state pointers and occupancy; flags are registered from these so they track accepted ops.
    always_comb begin
        wr_ptr_nxt = wr_ptr + {{PTR_WIDTH{1'b0}}, wr_accept};
        rd_ptr_nxt = rd_ptr + {{PTR_WIDTH{1'b0}}, rd_accept};
        count_nxt  = count;
        case ({wr_accept, rd_accept})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            oflow        <= 1'b0;
            uflow        <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            empty        <= (wr_ptr_nxt == rd_ptr_nxt);
            full         <= (wr_ptr_nxt[PTR_WIDTH] != rd_ptr_nxt[PTR_WIDTH]) &&
                            (wr_ptr_nxt[PTR_WIDTH-1:0] == rd_ptr_nxt[PTR_WIDTH-1:0]);
            almost_full  <= (count_nxt >= AFULL_LVL);
            almost_empty <= (count_nxt <= AEMPTY_LVL);
            oflow        <= wr_en & full;
            uflow        <= rd_en & empty;
        end
    end

    // Storage holds no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge aclk) begin
        if (wr_accept) begin
            mem[wr_ptr[PTR_WIDTH-1:0]] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = mem[rd_ptr[PTR_WIDTH-1:0]];
    assign rd_valid = ~empty;
`else
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_data <= mem[rd_ptr[PTR_WIDTH-1:0]];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model plus directed scenarios.
// Handles both the standard build and the SYNC_FIFO_FWFT_EN build.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int PW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          aclk    = 1'b0;
    logic          areset  = 1'b1;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, full, empty, almost_full, almost_empty, oflow, uflow;
    logic [PW:0]   count;

    int tests_run    = 0;
    int tests_failed = 0;

    sync_fifo #(
        .DATA_WIDTH(DW), .PTR_WIDTH(PW), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
    ) dut (
        .aclk(aclk), .areset(areset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .oflow(oflow), .uflow(uflow)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Reference model: the FIFO is just a queue; accept decisions use occupancy before the edge.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] m_rd_data  = '0;
    logic          m_rd_valid = 1'b0;
    logic          m_oflow    = 1'b0;
    logic          m_uflow    = 1'b0;
    bit            m_wa, m_ra;

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            model_q.delete();
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
            m_oflow    = 1'b0;
            m_uflow    = 1'b0;
        end else begin
            m_wa    = wr_en && (model_q.size() < DEPTH);
            m_ra    = rd_en && (model_q.size() > 0);
            m_oflow = wr_en && !m_wa;
            m_uflow = rd_en && !m_ra;
`ifdef SYNC_FIFO_FWFT_EN
            if (m_ra) void'(model_q.pop_front());
`else
            m_rd_valid = m_ra;
            if (m_ra) m_rd_data = model_q.pop_front();
`endif
            if (m_wa) model_q.push_back(wr_data);
        end
    end

    // Every cycle: compare all DUT outputs against what the queue model implies.
    always @(negedge aclk) begin
        int n;
        n = model_q.size();
        checkOutput("count",        int'(count),        n);
        checkOutput("full",         int'(full),         int'(n == DEPTH));
        checkOutput("empty",        int'(empty),        int'(n == 0));
        checkOutput("almost_full",  int'(almost_full),  int'(n >= AF));
        checkOutput("almost_empty", int'(almost_empty), int'(n <= AE));
        checkOutput("oflow",        int'(oflow),        int'(m_oflow));
        checkOutput("uflow",        int'(uflow),        int'(m_uflow));
`ifdef SYNC_FIFO_FWFT_EN
        checkOutput("rd_valid",     int'(rd_valid),     int'(n != 0));
        if (n != 0) checkOutput("rd_data", int'(rd_data), int'(model_q[0]));
`else
        checkOutput("rd_valid",     int'(rd_valid),     int'(m_rd_valid));
        checkOutput("rd_data",      int'(rd_data),      int'(m_rd_data));
`endif
    end

    // One clock of stimulus; returns just after the edge so its effects are visible.
    task automatic applyStimulus(input logic wr, input logic [DW-1:0] d, input logic rd);
        @(negedge aclk);
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        @(posedge aclk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        checkOutput("rst_empty",        int'(empty),        1);
        checkOutput("rst_almost_empty", int'(almost_empty), 1);
        checkOutput("rst_full",         int'(full),         0);
        checkOutput("rst_count",        int'(count),        0);
        checkOutput("rst_rd_valid",     int'(rd_valid),     0);
        checkOutput("rst_oflow",        int'(oflow),        0);
        checkOutput("rst_uflow",        int'(uflow),        0);

`ifndef SYNC_FIFO_FWFT_EN
        applyStimulus(1'b1, 8'h11, 1'b0);
        checkOutput("fill1_count", int'(count), 1);
        checkOutput("fill1_aempty", int'(almost_empty), 1);
        applyStimulus(1'b1, 8'h22, 1'b0);
        checkOutput("fill2_count", int'(count), 2);
        checkOutput("fill2_aempty", int'(almost_empty), 0);
        applyStimulus(1'b1, 8'h33, 1'b0);
        checkOutput("fill3_count", int'(count), 3);
        checkOutput("fill3_afull", int'(almost_full), 1);
        checkOutput("fill3_full", int'(full), 0);
        applyStimulus(1'b1, 8'h44, 1'b0);
        checkOutput("fill4_count", int'(count), 4);
        checkOutput("fill4_full", int'(full), 1);
        checkOutput("model_size_full", model_q.size(), 4);
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("ovf_oflow", int'(oflow), 1);
        checkOutput("ovf_count", int'(count), 4);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("ovf_pulse_end", int'(oflow), 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("drain_valid", int'(rd_valid), 1);
            checkOutput("drain_data", int'(rd_data), 17 * (i + 1));
        end
        checkOutput("drain_empty", int'(empty), 1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("udf_uflow", int'(uflow), 1);
        checkOutput("udf_valid", int'(rd_valid), 0);
        checkOutput("udf_data_hold", int'(rd_data), 8'h44);

        applyStimulus(1'b1, 8'h01, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(i + 3), 1'b1);
            checkOutput("sim_count", int'(count), 2);
            checkOutput("sim_data", int'(rd_data), i + 1);
        end

        applyStimulus(1'b1, 8'h0D, 1'b0);
        applyStimulus(1'b1, 8'h0E, 1'b0);
        checkOutput("simfull_pre", int'(full), 1);
        applyStimulus(1'b1, 8'hEE, 1'b1);
        checkOutput("simfull_count", int'(count), 3);
        checkOutput("simfull_oflow", int'(oflow), 1);
        checkOutput("simfull_data", int'(rd_data), 8'h0B);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("redrain_data", int'(rd_data), 12 + i);
        end
        applyStimulus(1'b1, 8'h77, 1'b1);
        checkOutput("simempty_count", int'(count), 1);
        checkOutput("simempty_uflow", int'(uflow), 1);
        checkOutput("simempty_valid", int'(rd_valid), 0);
        checkOutput("simempty_hold", int'(rd_data), 8'h0E);

        applyStimulus(1'b1, 8'h78, 1'b0);
        applyStimulus(1'b1, 8'h79, 1'b0);
        checkOutput("prerst_count", int'(count), 3);
        @(posedge aclk);
        #2 areset = 1'b1;
        #1;
        checkOutput("midrst_count", int'(count), 0);
        checkOutput("midrst_empty", int'(empty), 1);
        checkOutput("midrst_aempty", int'(almost_empty), 1);
        checkOutput("midrst_full", int'(full), 0);
        checkOutput("midrst_afull", int'(almost_full), 0);
        checkOutput("midrst_rd_data", int'(rd_data), 0);
        checkOutput("midrst_rd_valid", int'(rd_valid), 0);
        @(negedge aclk);
        areset = 1'b0;
        applyStimulus(1'b1, 8'hA5, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("postrst_data", int'(rd_data), 8'hA5);
        checkOutput("postrst_valid", int'(rd_valid), 1);
        checkOutput("model_size_end", model_q.size(), 0);
`else
        applyStimulus(1'b1, 8'h5A, 1'b0);
        checkOutput("fwft_valid", int'(rd_valid), 1);
        checkOutput("fwft_data", int'(rd_data), 8'h5A);
        checkOutput("fwft_count", int'(count), 1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("fwft_hold_valid", int'(rd_valid), 1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("fwft_pop_valid", int'(rd_valid), 0);
        checkOutput("fwft_pop_count", int'(count), 0);

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(17 * (i + 1)), 1'b0);
        checkOutput("fwft_full", int'(full), 1);
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("fwft_oflow", int'(oflow), 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("fwft_head", int'(rd_data), 17 * (i + 1));
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("fwft_uflow", int'(uflow), 1);
        checkOutput("fwft_udf_valid", int'(rd_valid), 0);
`endif

        repeat (2) @(negedge aclk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
